// File: rtl/aes_round_seq.sv
// Iterative AES-128 sequencer wrapped around an external single-round combinational datapath.
// Latency: input accepted at edge k, out_valid high after edge k+10; 12-cycle accept-to-accept minimum.
// Backpressure: in_ready only in IDLE; ciphertext held in DONE until out_ready, no new block accepted meanwhile.
module aes_round_seq #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy,
    output logic [127:0] rnd_state_o,
    output logic [127:0] rnd_key_o,
    output logic [7:0]   rnd_rcon_o,
    input  logic [127:0] rnd_state_i,
    input  logic [127:0] rnd_key_i
);

    // Only the AES-128 schedule (ten rounds, rcon ending at 8'h36) is implemented.
    if (NR != 10) begin : g_bad_nr
        $error("aes_round_seq: only NR = 10 (AES-128) is supported");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm;
    fsm_t         fsm_nxt;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] ct_reg;
    logic [7:0]   rcon_reg;
    logic [3:0]   cnt;
    logic         last_round;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    assign last_round = (cnt == 4'(NR));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state logic and handshake/status outputs decoded from the state.
    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    fsm_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_round) begin
                    fsm_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_nxt = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Block state, round key, rcon and round counter; loaded on accept, advanced each RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            ct_reg    <= '0;
            rcon_reg  <= 8'h00;
            cnt       <= 4'd0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        state_reg <= plaintext ^ key;
                        key_reg   <= key;
                        rcon_reg  <= 8'h01;
                        cnt       <= 4'd1;
                    end
                end
                RUN: begin
                    state_reg <= rnd_state_i;
                    key_reg   <= rnd_key_i;
                    if (last_round) begin
                        // Park rcon at zero so the datapath never sees 8'h36 outside RUN.
                        ct_reg   <= rnd_state_i;
                        rcon_reg <= 8'h00;
                        cnt      <= 4'd0;
                    end else begin
                        rcon_reg <= xtime(rcon_reg);
                        cnt      <= cnt + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ciphertext  = ct_reg;
    assign rnd_state_o = state_reg;
    assign rnd_key_o   = key_reg;
    assign rnd_rcon_o  = rcon_reg;

endmodule

// File: tb/tb_aes_round_seq.sv
// Bench for aes_round_seq with a behavioural AES round closed around the sequencer's datapath ports.
// Known-answer and random vectors checked against a whole-block AES-128 reference function.
// Covers latency, rcon sequencing, backpressure, mid-run reset and back-to-back acceptance.
module tb_aes_round_seq;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;
    logic         busy;
    logic [127:0] rnd_state_o;
    logic [127:0] rnd_key_o;
    logic [7:0]   rnd_rcon_o;
    logic [127:0] rnd_state_i;
    logic [127:0] rnd_key_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aes_round_seq #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key),
        .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext), .busy(busy),
        .rnd_state_o(rnd_state_o), .rnd_key_o(rnd_key_o), .rnd_rcon_o(rnd_rcon_o),
        .rnd_state_i(rnd_state_i), .rnd_key_i(rnd_key_i)
    );

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq  = x;
        logic [7:0] inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [7:0]   c0, c1, c2, c3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = a[4*((c+r)%4)+r];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
                b[4*c]   = gmul(c0, 8'h02) ^ gmul(c1, 8'h03) ^ c2 ^ c3;
                b[4*c+1] = c0 ^ gmul(c1, 8'h02) ^ gmul(c2, 8'h03) ^ c3;
                b[4*c+2] = c0 ^ c1 ^ gmul(c2, 8'h02) ^ gmul(c3, 8'h03);
                b[4*c+3] = gmul(c0, 8'h03) ^ c1 ^ c2 ^ gmul(c3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i] ^ rk[127-8*i -: 8];
        return o;
    endfunction

    // Whole-block reference: AddRoundKey then ten rounds, final round without MixColumns.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] st = pt ^ k;
        logic [127:0] rk = k;
        logic [7:0]   rc = 8'h01;
        for (int r = 1; r <= 10; r++) begin
            rk = next_key(rk, rc);
            st = aes_round(st, rk, r == 10);
            rc = gmul(rc, 8'h02);
        end
        return st;
    endfunction

    // Combinational round datapath closing the loop, final round detected from rcon.
    assign rnd_key_i   = next_key(rnd_key_o, rnd_rcon_o);
    assign rnd_state_i = aes_round(rnd_state_o, next_key(rnd_key_o, rnd_rcon_o), rnd_rcon_o == 8'h36);

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present a block from IDLE (called at a negedge); returns at the negedge of RUN cycle 1.
    task automatic accept(input logic [127:0] pt, input logic [127:0] k, input string tag);
        chkb({tag, "_in_ready_idle"}, in_ready, 1'b1);
        plaintext = pt;
        key       = k;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // From the negedge of RUN cycle 1, follow the block to DONE checking rcon, latency and result.
    task automatic wait_done(input logic [127:0] exp_ct, input string tag);
        int         edges = 0;
        logic [7:0] exp_rc = 8'h01;
        while (!out_valid && edges < 40) begin
            if (edges < 10) begin
                chk8({tag, "_rcon"}, rnd_rcon_o, exp_rc);
                chkb({tag, "_busy"}, busy, 1'b1);
                exp_rc = gmul(exp_rc, 8'h02);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        chki({tag, "_latency"}, edges, 10);
        chk({tag, "_ciphertext"}, ciphertext, exp_ct);
        chk8({tag, "_rcon_done"}, rnd_rcon_o, 8'h00);
        chkb({tag, "_in_ready_done"}, in_ready, 1'b0);
    endtask

    // Complete the output handshake (out_ready already high) and confirm return to IDLE.
    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chkb({tag, "_out_valid_after_hs"}, out_valid, 1'b0);
        chkb({tag, "_in_ready_after_hs"}, in_ready, 1'b1);
        chk8({tag, "_rcon_idle"}, rnd_rcon_o, 8'h00);
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t         vecs [6];
    logic [127:0] held_ct;
    logic [127:0] ct_a;
    logic         got_a;
    logic         saw_valid;
    int           e;

    initial begin
        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        for (int i = 2; i < 6; i++) begin
            vecs[i].pt  = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
            vecs[i].ct  = aes_ref(vecs[i].pt, vecs[i].key);
        end

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; plaintext = '0; key = '0;
        #12;
        chkb("rst_in_ready", in_ready, 1'b1);
        chkb("rst_out_valid", out_valid, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chk("rst_ciphertext", ciphertext, 128'h0);
        chk("rst_state_o", rnd_state_o, 128'h0);
        chk("rst_key_o", rnd_key_o, 128'h0);
        chk8("rst_rcon", rnd_rcon_o, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors with out_ready held high
        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].pt, vecs[i].key, $sformatf("vec%0d", i));
            wait_done(vecs[i].ct, $sformatf("vec%0d", i));
            handshake($sformatf("vec%0d", i));
        end

        // Backpressure: hold DONE, second in_valid must be ignored, including on the handshake edge
        out_ready = 1'b0;
        accept(vecs[2].pt, vecs[2].key, "bp");
        wait_done(vecs[2].ct, "bp");
        held_ct   = ciphertext;
        plaintext = vecs[1].pt;
        key       = vecs[1].key;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_ct_stable", ciphertext, vecs[2].ct);
            chkb("bp_out_valid_hold", out_valid, 1'b1);
            chkb("bp_in_ready_hold", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chkb("bp_out_valid_after_hs", out_valid, 1'b0);
        chkb("bp_in_ready_after_hs", in_ready, 1'b1);
        chkb("bp_not_accepted_in_done", busy, 1'b0);
        accept(vecs[1].pt, vecs[1].key, "bp2");
        wait_done(vecs[1].ct, "bp2");
        handshake("bp2");

        // Asynchronous reset in the middle of RUN cycle 5
        accept(vecs[3].pt, vecs[3].key, "rst_mid");
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        chkb("rst_mid_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chkb("rst_mid_busy", busy, 1'b0);
        chkb("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_state_o", rnd_state_o, 128'h0);
        chk("rst_mid_key_o", rnd_key_o, 128'h0);
        chk8("rst_mid_rcon", rnd_rcon_o, 8'h00);
        chk("rst_mid_ct", ciphertext, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chkb("rst_mid_no_output", saw_valid, 1'b0);
        accept(vecs[1].pt, vecs[1].key, "post_rst");
        wait_done(vecs[1].ct, "post_rst");
        handshake("post_rst");

        // Back-to-back: in_valid held high, interval between accepts must be 12 cycles
        plaintext = vecs[0].pt;
        key       = vecs[0].key;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        plaintext = vecs[4].pt;
        key       = vecs[4].key;
        e = 0;
        got_a = 1'b0;
        ct_a = '0;
        while (e < 40) begin
            if (out_valid) begin
                ct_a  = ciphertext;
                got_a = 1'b1;
            end
            @(posedge clk);
            e++;
            @(negedge clk);
            if (busy && got_a) break;
        end
        in_valid = 1'b0;
        chki("b2b_interval", e, 12);
        chk("b2b_ct_a", ct_a, vecs[0].ct);
        wait_done(vecs[4].ct, "b2b_b");
        handshake("b2b_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_seq.md
Name: aes_round_seq

Overview:
- Iterative AES-128 encryption sequencer that sits directly upstream of the single-round datapath `round`.
- Accepts a plaintext/key pair with a valid/ready handshake and performs the initial AddRoundKey.
- Feeds the round datapath once per cycle for 10 cycles, supplying state, round key and rcon, and registers the datapath's state and key outputs back.
- Presents the ciphertext on a valid/ready output handshake.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a synthesis-time error.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  plaintext/key pair valid
- in_ready  output  1  sequencer can accept a pair
- plaintext  input  128  block to encrypt, bit 127 = byte 0
- key  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext valid
- out_ready  input  1  consumer accepts ciphertext
- ciphertext  output  128  encrypted block
- busy  output  1  high in RUN
- rnd_state_o  output  128  state to round datapath `in`
- rnd_key_o  output  128  key to round datapath `keyin`
- rnd_rcon_o  output  8  rcon to round datapath `rcon`
- rnd_state_i  input  128  round datapath `out`
- rnd_key_i  input  128  round datapath `keyout`

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (asynchronous, any time, including mid-RUN):
  - FSM goes to IDLE; state_reg, key_reg, ciphertext = 0; rcon_reg = 8'h00; round counter = 0.
  - Outputs: in_ready = 1 after reset release, out_valid = 0, busy = 0.
  - An in-flight block is discarded and no output is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On a clk edge with in_valid = 1: state_reg <= plaintext ^ key (initial AddRoundKey), key_reg <= key, rcon_reg <= 8'h01, cnt <= 1, go to RUN.
- RUN:
  - in_ready = 0 and busy = 1; in_valid is ignored.
  - Each edge: state_reg <= rnd_state_i, key_reg <= rnd_key_i, rcon_reg <= xtime(rcon_reg), cnt <= cnt + 1.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00).
  - rcon sequence across the ten RUN cycles: 01,02,04,08,10,20,40,80,1B,36.
  - On the edge where cnt == NR (rcon_reg == 8'h36): ciphertext <= rnd_state_i, rcon_reg <= 8'h00, go to DONE.
- DONE:
  - out_valid = 1; ciphertext is held stable until the handshake.
  - On an edge with out_ready = 1: out_valid <= 0, in_ready <= 1, go to IDLE.
  - out_ready already high on the first DONE cycle completes the handshake on that edge.
  - out_ready low holds DONE indefinitely; no new input is accepted (in_ready = 0).
- Round datapath drive:
  - rnd_state_o = state_reg, rnd_key_o = key_reg, rnd_rcon_o = rcon_reg, all direct from registers with no combinational path from inputs.
  - rcon_reg is 8'h00 outside RUN, so the datapath's final-round detection (rcon == 8'h36) never fires spuriously.
  - The datapath is purely combinational; one full round, including key expansion, completes per cycle.
- Latency and throughput:
  - Input accepted at edge k → out_valid high after edge k+10.
  - Minimum accept-to-accept interval is 12 cycles (10 RUN + 1 DONE + 1 IDLE).
- Simultaneous events: in_valid asserted during DONE, even in the same cycle as out_ready, is not accepted; acceptance happens only from IDLE.
- Width rules: all XORs are 128-bit; rcon arithmetic is modulo the AES polynomial via xtime only.

Test Plan:
- Bench instantiates aes_round_seq plus `round` wired back-to-back. FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c, out_ready = 1 → out_valid exactly 10 cycles after accept, ciphertext 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
- Monitor rnd_rcon_o over one block → exactly 01,02,04,08,10,20,40,80,1B,36 on consecutive RUN cycles, and 00 in IDLE/DONE.
- Backpressure: out_ready = 0 for 5 cycles after out_valid → ciphertext stable, in_ready = 0, second in_valid ignored; raise out_ready → handshake, in_ready = 1 next cycle, second block accepted and correct.
- Reset mid-operation: assert rst_n = 0 asynchronously at RUN cycle 5 → outputs zero immediately, in_ready = 1 after release, no out_valid; next block (App. C.1) produces the correct ciphertext.
- Back-to-back blocks with in_valid held high and out_ready = 1 → accept-to-accept interval of 12 cycles, both ciphertexts correct.
